cpu_mem_responder: RTL and testbench
====================================

CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 11: memory word-address width; the array holds 2^ADDR_W words of 32 bits.
REQ-002 Parameter WBUF_DEPTH, default 4: number of write-buffer entries; must be a power of two, minimum 2.
REQ-003 clk  in  1: single clock; all state updates on its rising edge.
REQ-004 resetn  in  1: asynchronous, active-high reset (1 = reset asserted), as already decided for this block.
REQ-005 read_mem  in  1: read request, sampled at the clk edge.
REQ-006 mem_radrs  in  ADDR_W: read word address.
REQ-007 write_mem  in  1: write request, sampled at the clk edge.
REQ-008 mem_wadrs  in  ADDR_W: write word address.
REQ-009 result  in  32: write data.
REQ-010 instruction_fetch  out  32: registered read data.
REQ-011 rdata_valid  out  1: high for one cycle when instruction_fetch carries new read data.
REQ-012 wbuf_full  out  1: write buffer holds WBUF_DEPTH entries.
REQ-013 wbuf_empty  out  1: write buffer holds 0 entries.
REQ-014 write_overflow  out  1: sticky flag indicating a write was dropped.

Function
REQ-015 The memory array shall be single-ported: one read or one drain write per cycle.
REQ-016 Read latency shall be 1 cycle: read_mem=1 at edge N drives instruction_fetch and rdata_valid=1 after edge N.
REQ-017 rdata_valid shall be 0 after any edge with read_mem=0; instruction_fetch shall hold its last value.
REQ-018 Read data shall come from the youngest write-buffer entry whose address matches mem_radrs, taken from buffer contents before the edge; with no match, data comes from the array.
REQ-019 A write issued at the same edge as a read to the same address shall not be visible to that read, since the read returns the pre-edge value.
REQ-020 write_mem=1 shall enqueue {mem_wadrs, result} at the FIFO tail when the buffer is not full, or when it is full and a drain occurs at the same edge.
REQ-021 Drain: at each edge with read_mem=0 and the buffer non-empty, the head entry shall be written to the array and popped.
REQ-022 No drain shall occur at any edge with read_mem=1; the array read takes priority.
REQ-023 Occupancy shall change by +1 (enqueue only), -1 (drain only), or 0 (both or neither); it shall never exceed WBUF_DEPTH.
REQ-024 A write arriving when the buffer is full and read_mem=1 shall be dropped, and write_overflow shall be set to 1 until reset.
REQ-025 Head and tail pointers shall wrap modulo WBUF_DEPTH.
REQ-026 wbuf_full and wbuf_empty shall be registered and shall reflect occupancy after each edge.
REQ-027 Multiple buffered writes to the same address shall drain in FIFO order, so the last write wins in the array.

Reset
REQ-028 While resetn=1, the block shall asynchronously force instruction_fetch=0, rdata_valid=0, wbuf_full=0, wbuf_empty=1, write_overflow=0, pointers=0 and occupancy=0.
REQ-029 Reset shall not clear the array contents.
REQ-030 Buffered writes not yet drained when reset asserts shall be discarded.
REQ-031 The first edge after resetn falls shall be a normal operating edge.

Verification
REQ-032 Write 0xDEADBEEF to address 5, idle 1 cycle, then read address 5 -> wbuf_empty=1 before the read; one cycle after the read, instruction_fetch=0xDEADBEEF and rdata_valid=1.
REQ-033 Hold read_mem=1 continuously and write 0x11 then 0x22 to address 7, then read address 7 -> returns 0x22 by forwarding; drop read_mem -> 2 drain cycles, then array[7]=0x22.
REQ-034 Hold read_mem=1 and issue 5 writes to addresses 0..4 with data 0xA0..0xA4 -> wbuf_full=1 after the 4th write; the 5th write is dropped and write_overflow=1; after release, array[0..3]=0xA0..0xA3 and array[4] is unchanged.
REQ-035 With the buffer full and read_mem=0, write address 9 with data 0x55 -> accepted; occupancy stays 4 and write_overflow stays 0.
REQ-036 With 3 writes buffered and read_mem=1, assert resetn mid-cycle -> outputs take their reset values immediately; after release, wbuf_empty=1 and no array location was modified.
REQ-037 At the same edge, read address 3 and write address 3 with data 0x77, where array[3]=0x10 -> the read returns 0x10; a read on the next cycle returns 0x77.

Source files
------------

// File: rtl/cpu_mem_responder.sv
// Single-ported 32-bit word memory with a 1-cycle registered read port and a
// FIFO write buffer that drains only on cycles without a read.
module cpu_mem_responder #(
  parameter int ADDR_W     = 11,
  parameter int WBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              read_mem,
  input  logic [ADDR_W-1:0] mem_radrs,
  input  logic              write_mem,
  input  logic [ADDR_W-1:0] mem_wadrs,
  input  logic [31:0]       result,
  output logic [31:0]       instruction_fetch,
  output logic              rdata_valid,
  output logic              wbuf_full,
  output logic              wbuf_empty,
  output logic              write_overflow
);

  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(WBUF_DEPTH);

  logic [31:0]       mem      [2**ADDR_W];
  logic [ADDR_W-1:0] buf_adrs [WBUF_DEPTH];
  logic [31:0]       buf_data [WBUF_DEPTH];

  logic [PW-1:0] head, tail, idx;
  logic [CW-1:0] count, count_next;
  logic          drain, enq, drop, hit;
  logic [31:0]   fwd_data;

  // Scan oldest to youngest so the last match found is the youngest entry.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    idx      = head;
    for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count && buf_adrs[idx] == mem_radrs) begin
        hit      = 1'b1;
        fwd_data = buf_data[idx];
      end
    end
  end

  always_comb begin
    drain = !read_mem && (count != '0);
    enq   = write_mem && ((count != DEPTH_C) || drain);
    drop  = write_mem && !enq;
    count_next = count;
    case ({enq, drain})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      wbuf_full         <= 1'b0;
      wbuf_empty        <= 1'b1;
      write_overflow    <= 1'b0;
      rdata_valid       <= 1'b0;
      instruction_fetch <= '0;
    end else begin
      head        <= head + PW'(drain);
      tail        <= tail + PW'(enq);
      count       <= count_next;
      wbuf_full   <= (count_next == DEPTH_C);
      wbuf_empty  <= (count_next == '0);
      rdata_valid <= read_mem;
      if (drop)
        write_overflow <= 1'b1;
      if (read_mem)
        instruction_fetch <= hit ? fwd_data : mem[mem_radrs];
    end
  end

  // Storage is never reset; reset forces count to 0 so no drain can occur.
  always_ff @(posedge clk) begin
    if (enq) begin
      buf_adrs[tail] <= mem_wadrs;
      buf_data[tail] <= result;
    end
    if (drain)
      mem[buf_adrs[head]] <= buf_data[head];
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder: directed reads push expected data,
// a negedge monitor pops and compares on rdata_valid.
module tb_cpu_mem_responder;

  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              resetn = 1'b1;
  logic              read_mem = 1'b0;
  logic [ADDR_W-1:0] mem_radrs = '0;
  logic              write_mem = 1'b0;
  logic [ADDR_W-1:0] mem_wadrs = '0;
  logic [31:0]       result = '0;
  logic [31:0]       instruction_fetch;
  logic              rdata_valid, wbuf_full, wbuf_empty, write_overflow;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb [$];

  cpu_mem_responder #(.ADDR_W(ADDR_W), .WBUF_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .read_mem(read_mem), .mem_radrs(mem_radrs),
    .write_mem(write_mem), .mem_wadrs(mem_wadrs), .result(result),
    .instruction_fetch(instruction_fetch), .rdata_valid(rdata_valid),
    .wbuf_full(wbuf_full), .wbuf_empty(wbuf_empty),
    .write_overflow(write_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every valid read beat must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!resetn && rdata_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rdata: got 0x%08h expected no read", instruction_fetch);
      end else begin
        check("rdata", instruction_fetch, sb.pop_front());
      end
    end
  end

  task automatic cyc(input logic rd, input logic [ADDR_W-1:0] ra, input logic [31:0] exp,
                     input logic wr, input logic [ADDR_W-1:0] wa, input logic [31:0] wd);
    read_mem  = rd;
    mem_radrs = ra;
    write_mem = wr;
    mem_wadrs = wa;
    result    = wd;
    if (rd) sb.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] ra, input logic [31:0] exp);
    cyc(1'b1, ra, exp, 1'b0, '0, '0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_if", instruction_fetch, 32'h0);
    check("rst_valid", {31'b0, rdata_valid}, 32'h0);
    check("rst_full", {31'b0, wbuf_full}, 32'h0);
    check("rst_empty", {31'b0, wbuf_empty}, 32'h1);
    check("rst_ovf", {31'b0, write_overflow}, 32'h0);
    resetn = 1'b0;

    // Known array background
    cyc(1'b0, '0, '0, 1'b1, 11'd3, 32'h10);
    cyc(1'b0, '0, '0, 1'b1, 11'd4, 32'h44);
    idle(1);
    check("pre_empty", {31'b0, wbuf_empty}, 32'h1);

    // Write, drain, read back
    cyc(1'b0, '0, '0, 1'b1, 11'd5, 32'hDEADBEEF);
    check("w5_empty_after_enq", {31'b0, wbuf_empty}, 32'h0);
    idle(1);
    check("w5_empty_before_read", {31'b0, wbuf_empty}, 32'h1);
    rd(11'd5, 32'hDEADBEEF);
    check("r5_valid", {31'b0, rdata_valid}, 32'h1);

    // Same-edge read/write returns the pre-edge value, then forwarding
    cyc(1'b1, 11'd3, 32'h10, 1'b1, 11'd3, 32'h77);
    rd(11'd3, 32'h77);
    idle(1);
    check("hold_valid", {31'b0, rdata_valid}, 32'h0);
    check("hold_if", instruction_fetch, 32'h77);

    // Two writes to one address under continuous reads; youngest forwarded
    cyc(1'b1, 11'd5, 32'hDEADBEEF, 1'b1, 11'd7, 32'h11);
    cyc(1'b1, 11'd5, 32'hDEADBEEF, 1'b1, 11'd7, 32'h22);
    rd(11'd7, 32'h22);
    idle(2);
    check("a7_drained", {31'b0, wbuf_empty}, 32'h1);
    rd(11'd7, 32'h22);

    // Full buffer with a concurrent drain still accepts a write
    cyc(1'b1, 11'd4, 32'h44, 1'b1, 11'd10, 32'hB0);
    cyc(1'b1, 11'd4, 32'h44, 1'b1, 11'd11, 32'hB1);
    cyc(1'b1, 11'd4, 32'h44, 1'b1, 11'd12, 32'hB2);
    cyc(1'b1, 11'd4, 32'h44, 1'b1, 11'd13, 32'hB3);
    check("b_full", {31'b0, wbuf_full}, 32'h1);
    cyc(1'b0, '0, '0, 1'b1, 11'd9, 32'h55);
    check("b_full_kept", {31'b0, wbuf_full}, 32'h1);
    check("b_ovf_clear", {31'b0, write_overflow}, 32'h0);
    idle(4);
    check("b_empty", {31'b0, wbuf_empty}, 32'h1);
    rd(11'd9, 32'h55);
    rd(11'd10, 32'hB0);
    rd(11'd13, 32'hB3);

    // Overflow: fifth write while reading with a full buffer is dropped
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 11'd5, 32'hDEADBEEF, 1'b1, 11'(i), 32'hA0 + 32'(i));
      if (i == 2) check("o_notfull3", {31'b0, wbuf_full}, 32'h0);
      if (i == 3) begin
        check("o_full4", {31'b0, wbuf_full}, 32'h1);
        check("o_ovf_before", {31'b0, write_overflow}, 32'h0);
      end
    end
    check("o_ovf_set", {31'b0, write_overflow}, 32'h1);
    idle(4);
    check("o_empty", {31'b0, wbuf_empty}, 32'h1);
    check("o_ovf_sticky", {31'b0, write_overflow}, 32'h1);
    for (int i = 0; i < 4; i++) rd(11'(i), 32'hA0 + 32'(i));
    rd(11'd4, 32'h44);

    // Asynchronous reset with three buffered writes
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 11'd5, 32'hDEADBEEF, 1'b1, 11'(i), 32'hC0 + 32'(i));
    #6;
    read_mem  = 1'b0;
    write_mem = 1'b0;
    resetn    = 1'b1;
    #1;
    check("ar_if", instruction_fetch, 32'h0);
    check("ar_valid", {31'b0, rdata_valid}, 32'h0);
    check("ar_empty", {31'b0, wbuf_empty}, 32'h1);
    check("ar_full", {31'b0, wbuf_full}, 32'h0);
    check("ar_ovf", {31'b0, write_overflow}, 32'h0);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    idle(1);
    check("ar_empty_after", {31'b0, wbuf_empty}, 32'h1);
    for (int i = 0; i < 3; i++) rd(11'(i), 32'hA0 + 32'(i));

    idle(3);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
